// File: rtl/vga_text_writer_if.sv
// CPU-side register window of the VGA text writer: a one-cycle write strobe
// with register select and data, plus the busy flag returned by the writer.
interface vga_text_writer_if;
  logic       cpu_wr;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       busy;

  modport master (output cpu_wr, output cpu_addr, output cpu_data, input busy);
  modport slave  (input cpu_wr, input cpu_addr, input cpu_data, output busy);
endinterface

// File: rtl/vga_text_writer.sv
// Terminal front-end for the VGA text display: turns CPU register writes into
// character/color RAM writes, tracks the cursor, interprets CR/LF/BS/FF and
// runs line/screen clears as back-to-back write sequences.
module vga_text_writer #(
  parameter int          COLS         = 40,
  parameter int          ROWS         = 30,
  parameter logic [7:0]  DEFAULT_ATTR = 8'hF0
) (
  input  logic                sys_clk,
  input  logic                reset,
  vga_text_writer_if.slave    cpu,
  output logic [5:0]          cur_col,
  output logic [5:0]          cur_row,
  output logic                vram_wr,
  output logic [12:0]         vram_addr,
  output logic [7:0]          vram_data
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [7:0] SPACE    = 8'h20;

  // The cursor advance after a printable character is resolved on the exit
  // edge of PUT_ATTR, so a following line clear starts with no gap.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PUT_CHAR   = 3'd1,
    PUT_ATTR   = 3'd2,
    CLR_LINE   = 3'd3,
    CLR_SCREEN = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [5:0]  col_r, col_s;
  logic [5:0]  row_r, row_s;
  logic [7:0]  attr_r, attr_s;
  logic [5:0]  fill_col_r, fill_col_s;
  logic [5:0]  fill_row_r, fill_row_s;
  logic        plane_r, plane_s;
  logic        bs_r, bs_s;
  logic        busy_r;
  logic        wr_s;
  logic [12:0] addr_s;
  logic [7:0]  data_s;

  // Row advance wraps to the top: there is no scrolling.
  function automatic logic [5:0] next_row(input logic [5:0] row);
    if (row == LAST_ROW) begin
      return 6'd0;
    end else begin
      return row + 6'd1;
    end
  endfunction

  assign cpu.busy = busy_r;
  assign cur_col  = col_r;
  assign cur_row  = row_r;

  // Next-state, cursor and next RAM write selection.
  always_comb begin
    state_s    = state_r;
    col_s      = col_r;
    row_s      = row_r;
    attr_s     = attr_r;
    fill_col_s = fill_col_r;
    fill_row_s = fill_row_r;
    plane_s    = plane_r;
    bs_s       = bs_r;
    wr_s       = 1'b0;
    addr_s     = vram_addr;
    data_s     = vram_data;
    case (state_r)
      IDLE: begin
        if (cpu.cpu_wr) begin
          case (cpu.cpu_addr)
            2'd0: begin
              if (cpu.cpu_data == 8'h0D) begin
                col_s = 6'd0;
              end else if (cpu.cpu_data == 8'h0A) begin
                col_s      = 6'd0;
                row_s      = next_row(row_r);
                state_s    = CLR_LINE;
                fill_col_s = 6'd0;
                plane_s    = 1'b0;
                wr_s       = 1'b1;
                addr_s     = {1'b0, next_row(row_r), 6'd0};
                data_s     = SPACE;
              end else if (cpu.cpu_data == 8'h08) begin
                if (col_r != 6'd0) begin
                  col_s   = col_r - 6'd1;
                  bs_s    = 1'b1;
                  state_s = PUT_CHAR;
                  wr_s    = 1'b1;
                  addr_s  = {1'b0, row_r, col_r - 6'd1};
                  data_s  = SPACE;
                end else begin
                  col_s = col_r;
                end
              end else if (cpu.cpu_data == 8'h0C) begin
                col_s      = 6'd0;
                row_s      = 6'd0;
                state_s    = CLR_SCREEN;
                fill_col_s = 6'd0;
                fill_row_s = 6'd0;
                plane_s    = 1'b0;
                wr_s       = 1'b1;
                addr_s     = 13'd0;
                data_s     = SPACE;
              end else if (cpu.cpu_data >= 8'h20) begin
                bs_s    = 1'b0;
                state_s = PUT_CHAR;
                wr_s    = 1'b1;
                addr_s  = {1'b0, row_r, col_r};
                data_s  = cpu.cpu_data;
              end else begin
                state_s = IDLE;
              end
            end
            2'd1: attr_s = cpu.cpu_data;
            2'd2: col_s = (cpu.cpu_data > {2'b00, LAST_COL}) ? LAST_COL : cpu.cpu_data[5:0];
            2'd3: row_s = (cpu.cpu_data > {2'b00, LAST_ROW}) ? LAST_ROW : cpu.cpu_data[5:0];
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      PUT_CHAR: begin
        state_s = PUT_ATTR;
        wr_s    = 1'b1;
        addr_s  = {1'b1, row_r, col_r};
        data_s  = attr_r;
      end
      PUT_ATTR: begin
        if (bs_r) begin
          state_s = IDLE;
        end else if (col_r != LAST_COL) begin
          col_s   = col_r + 6'd1;
          state_s = IDLE;
        end else begin
          col_s      = 6'd0;
          row_s      = next_row(row_r);
          state_s    = CLR_LINE;
          fill_col_s = 6'd0;
          plane_s    = 1'b0;
          wr_s       = 1'b1;
          addr_s     = {1'b0, next_row(row_r), 6'd0};
          data_s     = SPACE;
        end
      end
      CLR_LINE: begin
        if (!plane_r) begin
          plane_s = 1'b1;
          wr_s    = 1'b1;
          addr_s  = {1'b1, row_r, fill_col_r};
          data_s  = attr_r;
        end else if (fill_col_r != LAST_COL) begin
          fill_col_s = fill_col_r + 6'd1;
          plane_s    = 1'b0;
          wr_s       = 1'b1;
          addr_s     = {1'b0, row_r, fill_col_r + 6'd1};
          data_s     = SPACE;
        end else begin
          state_s = IDLE;
        end
      end
      CLR_SCREEN: begin
        if (!plane_r) begin
          plane_s = 1'b1;
          wr_s    = 1'b1;
          addr_s  = {1'b1, fill_row_r, fill_col_r};
          data_s  = attr_r;
        end else if (fill_col_r != LAST_COL) begin
          fill_col_s = fill_col_r + 6'd1;
          plane_s    = 1'b0;
          wr_s       = 1'b1;
          addr_s     = {1'b0, fill_row_r, fill_col_r + 6'd1};
          data_s     = SPACE;
        end else if (fill_row_r != LAST_ROW) begin
          fill_col_s = 6'd0;
          fill_row_s = fill_row_r + 6'd1;
          plane_s    = 1'b0;
          wr_s       = 1'b1;
          addr_s     = {1'b0, fill_row_r + 6'd1, 6'd0};
          data_s     = SPACE;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, cursor, attribute and registered RAM-port outputs.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      col_r      <= 6'd0;
      row_r      <= 6'd0;
      attr_r     <= DEFAULT_ATTR;
      fill_col_r <= 6'd0;
      fill_row_r <= 6'd0;
      plane_r    <= 1'b0;
      bs_r       <= 1'b0;
      busy_r     <= 1'b0;
      vram_wr    <= 1'b0;
      vram_addr  <= 13'd0;
      vram_data  <= 8'd0;
    end else begin
      state_r    <= state_s;
      col_r      <= col_s;
      row_r      <= row_s;
      attr_r     <= attr_s;
      fill_col_r <= fill_col_s;
      fill_row_r <= fill_row_s;
      plane_r    <= plane_s;
      bs_r       <= bs_s;
      busy_r     <= (state_s != IDLE);
      vram_wr    <= wr_s;
      vram_addr  <= addr_s;
      vram_data  <= data_s;
    end
  end

endmodule
